// File: rtl/mult_operand_stream.sv
// ---------------------------------------------------------------------------
// mult_operand_stream
//
// Streaming front-end for a 4x4 combinational array multiplier.
// Operand pairs (m,q) arrive over a valid/ready handshake and are queued in
// a small FIFO. One pair at a time is popped into an operand register that
// drives the external multiplier. The product is sampled one cycle later and
// offered downstream over a second valid/ready handshake. A wrapping counter
// tracks how many products have been handed off.
//
// Handshake rule (both sides): a transfer happens at a rising edge where
// valid and ready are both 1. The producer holds valid and data stable until
// the transfer. Ready/valid outputs of this block are registered-state
// functions only; they never depend combinationally on the partner's signal.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_in_valid     operand pair on i_in_m / i_in_q is valid
//   o_in_ready     block can accept a pair (FIFO not full)
//   i_in_m         multiplicand
//   i_in_q         multiplier
//   o_mult_m       multiplicand driven to the array multiplier
//   o_mult_q       multiplier operand driven to the array multiplier
//   i_mult_p       product returned by the array multiplier (combinational)
//   o_out_valid    o_out_p holds a product
//   i_out_ready    consumer takes o_out_p
//   o_out_p        unsigned 8-bit product
//   o_done_count   number of products handed off, wraps
//   o_fifo_level   number of pairs currently in the FIFO
//   o_state        debug view of the control FSM state
// ---------------------------------------------------------------------------
module mult_operand_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [3:0]                   i_in_m,
    input  logic [3:0]                   i_in_q,
    output logic [3:0]                   o_mult_m,
    output logic [3:0]                   o_mult_q,
    input  logic [7:0]                   i_mult_p,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [7:0]                   o_out_p,
    output logic [CNT_W-1:0]             o_done_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_level,
    output logic [1:0]                   o_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t              r_state;
    logic [7:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [3:0]          r_op_m;
    logic [3:0]          r_op_q;
    logic [7:0]          r_out_p;
    logic                r_out_valid;
    logic [CNT_W-1:0]    r_done_count;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    state_t              w_next_state;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_push;
    logic                w_pop;
    logic                w_capture;
    logic                w_handoff;

    // Full/empty come from the registered level only, so a pop in the same
    // cycle never makes room for a push, and a push into an empty FIFO is
    // not poppable until the following cycle.
    assign w_fifo_empty = (r_level == '0);
    assign w_fifo_full  = (r_level == LVL_W'(DEPTH));
    assign w_push       = i_in_valid & ~w_fifo_full;

    // -----------------------------------------------------------------------
    // Control FSM: next state and per-cycle strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_handoff    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_EVAL;
                end
            end
            S_EVAL: begin
                // Operands have been stable on o_mult_* for this whole cycle.
                w_capture    = 1'b1;
                w_next_state = S_OUT;
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_handoff = 1'b1;
                    // Chain straight into the next evaluation when work is
                    // waiting, giving one product every two cycles.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_EVAL;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Operand FIFO
    // -----------------------------------------------------------------------
    // Storage is not reset; the pointers and level define which entries are
    // live, so clearing them is enough to flush.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= {i_in_m, i_in_q};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leave the level unchanged.
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Operand register feeding the array multiplier
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_m <= '0;
            r_op_q <= '0;
        end else if (w_pop) begin
            {r_op_m, r_op_q} <= r_mem[r_rd_ptr];
        end
    end

    // -----------------------------------------------------------------------
    // Product register and output handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_p     <= i_mult_p;
            r_out_valid <= 1'b1;
        end else if (w_handoff) begin
            // out_p keeps the last product; only valid drops.
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done_count <= '0;
        end else if (w_handoff) begin
            r_done_count <= r_done_count + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_in_ready   = ~w_fifo_full;
    assign o_mult_m     = r_op_m;
    assign o_mult_q     = r_op_q;
    assign o_out_valid  = r_out_valid;
    assign o_out_p      = r_out_p;
    assign o_done_count = r_done_count;
    assign o_fifo_level = r_level;
    assign o_state      = r_state;

endmodule

// File: tb/tb_mult_operand_stream.sv
`timescale 1ns/1ps
module tb_mult_operand_stream;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_m;
    logic [3:0]       in_q;
    logic [3:0]       mult_m;
    logic [3:0]       mult_q;
    logic [7:0]       mult_p;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_p;
    logic [CNT_W-1:0] done_count;
    logic [LVL_W-1:0] fifo_level;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected products in hand-off order.
    logic [7:0] exp_q[$];

    // Combinational 4x4 unsigned multiplier attached to the operand outputs.
    assign mult_p = {4'b0, mult_m} * {4'b0, mult_q};

    mult_operand_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_m       (in_m),
        .i_in_q       (in_q),
        .o_mult_m     (mult_m),
        .o_mult_q     (mult_q),
        .i_mult_p     (mult_p),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_p      (out_p),
        .o_done_count (done_count),
        .o_fifo_level (fifo_level),
        .o_state      (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / check tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_m      = '0;
        in_q      = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"},  32'(out_valid),  0);
        check({tag, "_out_p"},      32'(out_p),      0);
        check({tag, "_mult_m"},     32'(mult_m),     0);
        check({tag, "_mult_q"},     32'(mult_q),     0);
        check({tag, "_done_count"}, 32'(done_count), 0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 0);
        check({tag, "_in_ready"},   32'(in_ready),   1);
    endtask

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        int unsigned r;
        r = int'(a) * int'(b);
        return r[7:0];
    endfunction

    // Push one pair, wait a bounded time for its product, take it.
    task automatic run_pair(input logic [3:0] m, input logic [3:0] q,
                            input logic [7:0] want, input string tag);
        bit seen;
        in_m      = m;
        in_q      = q;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else step();
        end
        check({tag, "_valid"}, 32'(seen), 1);
        check({tag, "_p"}, 32'(out_p), 32'(want));
        check({tag, "_model"}, 32'(out_p), 32'(prod(m, q)));
        step();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] obs;
        logic [7:0] held;
        logic [3:0] pm;
        logic [3:0] pq;
        logic [3:0] m_tab [4];
        logic [3:0] q_tab [4];
        logic [7:0] p_tab [4];
        bit         push_fire;
        bit         pop_fire;
        int         accepted;
        int         completed;
        int         cyc;
        int         n_prod;
        logic [7:0] first_p;

        // 1: reset values
        do_reset();
        check_reset_values("rst");

        // 2: single pair latency
        in_m = 4'd3; in_q = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        step();                                  // E0: push
        in_valid = 1'b0;
        check("single_lvl_e0",   32'(fifo_level), 1);
        check("single_ov_e0",    32'(out_valid), 0);
        step();                                  // E1: op_reg loaded
        check("single_mult_m",   32'(mult_m), 3);
        check("single_mult_q",   32'(mult_q), 5);
        check("single_ov_e1",    32'(out_valid), 0);
        check("single_lvl_e1",   32'(fifo_level), 0);
        step();                                  // E2: product valid
        check("single_ov_e2",    32'(out_valid), 1);
        check("single_p",        32'(out_p), 32'h0F);
        step();                                  // E3: handed off
        check("single_done",     32'(done_count), 1);
        check("single_ov_e3",    32'(out_valid), 0);

        // 3: arithmetic corners
        m_tab = '{4'd15, 4'd0, 4'd1, 4'd8};
        q_tab = '{4'd15, 4'd9, 4'd15, 4'd2};
        p_tab = '{8'hE1, 8'h00, 8'h0F, 8'h10};
        for (int i = 0; i < 4; i++) begin
            run_pair(m_tab[i], q_tab[i], p_tab[i], $sformatf("corner%0d", i));
        end
        check("corner_done", 32'(done_count), 5);

        // 4: backpressure, DEPTH + 1 capacity
        do_reset();
        exp_q.delete();
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            in_m = 4'(i + 1);
            in_q = 4'(i + 2);
            in_valid = 1'b1;
            push_fire = in_ready;
            pm = in_m; pq = in_q;
            step();
            if (push_fire) begin
                exp_q.push_back(prod(pm, pq));
                accepted++;
            end
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 5);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_level",    32'(fifo_level), 4);
        check("bp_ov",       32'(out_valid), 1);
        held = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_p",  32'(out_p), 32'(held));
            check("bp_stall_ov", 32'(out_valid), 1);
            step();
        end
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            if (out_valid) begin
                obs = out_p;
                step();
                check("bp_order", 32'(obs), 32'(exp_q.pop_front()));
            end else begin
                step();
            end
            cyc++;
        end
        check("bp_drained", 32'(exp_q.size()), 0);
        check("bp_done",    32'(done_count), 5);

        // 5: random stress against scoreboard
        do_reset();
        exp_q.delete();
        accepted  = 0;
        completed = 0;
        cyc       = 0;
        while (completed < 300 && cyc < 20000) begin
            in_valid  = (accepted < 300) && ($urandom_range(0, 3) != 0);
            in_m      = 4'($urandom_range(0, 15));
            in_q      = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            push_fire = in_valid && in_ready;
            pop_fire  = out_valid && out_ready;
            obs = out_p;
            pm  = in_m;
            pq  = in_q;
            step();
            if (push_fire) begin
                exp_q.push_back(prod(pm, pq));
                accepted++;
            end
            if (pop_fire) begin
                if (exp_q.size() == 0) check("stress_extra", 1, 0);
                else check("stress_p", 32'(obs), 32'(exp_q.pop_front()));
                completed++;
            end
            check("stress_level_max", 32'(fifo_level <= LVL_W'(DEPTH)), 1);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stress_completed", 32'(completed), 300);
        check("stress_empty",     32'(exp_q.size()), 0);
        check("stress_done",      32'(done_count), 44);

        // 6: reset in the middle of operation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_m = 4'(i + 4);
            in_q = 4'(i + 1);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("midrst_pre_ov",  32'(out_valid), 1);
        check("midrst_pre_lvl", 32'(fifo_level), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("midrst");
        in_m = 4'd2; in_q = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_prod  = 0;
        first_p = '0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                if (n_prod == 0) first_p = out_p;
                n_prod++;
            end
            step();
        end
        check("midrst_nprod", 32'(n_prod), 1);
        check("midrst_p",     32'(first_p), 32'h0E);
        check("midrst_done",  32'(done_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
